cmd2apb_master: RTL and testbench
=================================

Name: cmd2apb_master

Overview:
Byte-stream command bridge acting as the APB master that drives apb2local.
- Parses framed read/write commands from a host byte link (UART/SPI receiver) into single APB transfers.
- Returns status and read data as a response byte stream.
- Sits between the host-link PHY and the apb2local → local2reg register path.

Parameters:
TIMEOUT_CYC, 1024, max ACCESS-phase cycles waiting for cfg_rdy_i before abort (≥2)
TO_W, $clog2(TIMEOUT_CYC+1), timeout counter width (derived, do not override)

Ports:
cfg_clk_i  in  1  clock
cfg_rstn_i  in  1  async active-low reset
rx_data_i  in  8  command byte
rx_vld_i  in  1  command byte valid
rx_rdy_o  out  1  bridge accepts byte (transfer when vld&rdy)
tx_data_o  out  8  response byte
tx_vld_o  out  1  response byte valid
tx_rdy_i  in  1  downstream accepts response byte
cfg_addr_o  out  32  APB address
cfg_sel_o  out  1  APB PSEL
cfg_ena_o  out  1  APB PENABLE
cfg_wr_o  out  1  APB PWRITE
cfg_wdata_o  out  32  APB write data
cfg_strb_o  out  4  APB byte strobes
cfg_rdata_i  in  32  APB read data
cfg_rdy_i  in  1  APB PREADY
busy_o  out  1  high whenever state != IDLE
timeout_cnt_o  out  16  saturating count of timed-out transfers

Behaviour:
- Clock and reset: single clock cfg_clk_i; reset cfg_rstn_i is asynchronous, active-low.
- Reset values: all outputs 0 except rx_rdy_o=1 (IDLE); state=IDLE; counters 0.
- Frame format:
  - Opcode byte: 0x57 = write, 0x52 = read.
  - 4 address bytes, MSB first.
  - Write only: 4 data bytes, MSB first.
- FSM states: IDLE, ADDR, DATA, SETUP, ACCESS, RESP.
- IDLE, on accepted byte:
  - 0x57 or 0x52: latch cfg_wr_o (1 for write, 0 for read), go to ADDR, byte_cnt=0.
  - Any other value: load single response 0x3F, go to RESP.
- ADDR: shift in 4 bytes (addr = {addr[23:0], byte}). After byte_cnt==3: write → DATA, read → SETUP.
- DATA: shift 4 bytes into cfg_wdata_o, then go to SETUP.
- Byte acceptance: rx_rdy_o=1 only in IDLE/ADDR/DATA. No inter-byte timeout; frame waits indefinitely.
- SETUP (exactly 1 cycle): cfg_sel_o=1, cfg_ena_o=0. Address, data and wr are stable from SETUP through the end of ACCESS.
- ACCESS: cfg_sel_o=1, cfg_ena_o=1, to_cnt increments each cycle.
  - cfg_rdy_i=1 sampled: transfer completes that cycle. For reads, cfg_rdata_i is captured in the same cycle, since apb2local gates rdata with ena&sel.
  - to_cnt reaches TIMEOUT_CYC-1 with cfg_rdy_i=0: abort, response 0x45, timeout_cnt_o += 1, saturating at 0xFFFF.
  - cfg_rdy_i=1 on the final timeout cycle counts as success (rdy wins).
- After ACCESS: cfg_sel_o and cfg_ena_o drop to 0 on the next cycle and stay 0 for ≥1 cycle. local2reg detects reads on the rising edge of rden, so back-to-back APB transfers without an idle gap are forbidden.
- cfg_strb_o: 4'hF during SETUP/ACCESS, 0 otherwise.
- cfg_addr_o: passed unmodified; bits [1:0] are sent as received.
- RESP sequences:
  - Write success: 0x4B.
  - Read success: 0x4B, then rdata[31:24], [23:16], [15:8], [7:0].
  - Timeout: 0x45.
  - Bad opcode: 0x3F.
- RESP handshake:
  - tx_vld_o held high with tx_data_o stable until tx_rdy_i=1; advance one byte per handshake.
  - After the last byte handshakes → IDLE.
  - tx_vld_o may be asserted in the first RESP cycle (registered output).
- Backpressure: while in RESP, rx_rdy_o=0; upstream bytes are held off, not dropped.
- Async reset mid-frame or mid-ACCESS: immediate return to IDLE with sel/ena/tx_vld at 0. A partially received frame is discarded. timeout_cnt_o is cleared.

Decomposition:
- Shared package cmd2apb_pkg:
  - Opcode constants OP_WR=8'h57, OP_RD=8'h52.
  - Response constants RSP_OK=8'h4B, RSP_TO=8'h45, RSP_BAD=8'h3F.
  - State enum (6 states, 3-bit).
- Single module; no sub-module is warranted. The response serializer is a 3-bit index into a 5-byte shift register inside RESP.

Test Plan:
1. Write: rx bytes 57 00 00 00 04 12 34 56 78 → one SETUP cycle (sel=1, ena=0, addr=0x4, wdata=0x12345678, wr=1, strb=F), then ACCESS until rdy. tx 4B. busy_o low afterwards.
2. Readback via apb2local+local2reg: rx 52 00 00 00 04 → ACCESS holds until rdat_vld (≈3 cycles). tx 4B 12 34 56 78. sel low ≥1 cycle before the next frame's SETUP.
3. Timeout: cfg_rdy_i tied 0, TIMEOUT_CYC=16, read frame → sel/ena drop after exactly 16 ACCESS cycles. tx 45. timeout_cnt_o=1. Next frame with rdy restored succeeds.
4. Bad opcode: rx 00 → tx 3F, no APB activity. A following valid write frame completes normally.
5. Backpressure: read frame with tx_rdy_i low for 20 cycles → tx_data_o stable at 4B, rx_rdy_o=0 throughout. Release → remaining 4 bytes in order.
6. Reset mid-ACCESS: cfg_rstn_i asserted during ACCESS → sel/ena/tx_vld 0 asynchronously. After release, the first byte 52 is accepted as an opcode.

Source files
------------

// File: rtl/cmd2apb_pkg.sv
// Shared constants, state encoding and helpers for the byte-stream to APB
// command bridge.
package cmd2apb_pkg;

   localparam logic [7:0] OP_WR   = 8'h57;
   localparam logic [7:0] OP_RD   = 8'h52;

   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_TO  = 8'h45;
   localparam logic [7:0] RSP_BAD = 8'h3F;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDR   = 3'd1,
      DATA   = 3'd2,
      SETUP  = 3'd3,
      ACCESS = 3'd4,
      RESP   = 3'd5
   } state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      logic [15:0] r;
      if (v == 16'hFFFF) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/cmd2apb_master.sv
// Framed byte-command parser driving a single-transfer APB master, with a
// serialized status/read-data response stream.
module cmd2apb_master
   import cmd2apb_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024,
   parameter int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic        cfg_clk_i,
   input  logic        cfg_rstn_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_vld_i,
   output logic        rx_rdy_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_vld_o,
   input  logic        tx_rdy_i,
   output logic [31:0] cfg_addr_o,
   output logic        cfg_sel_o,
   output logic        cfg_ena_o,
   output logic        cfg_wr_o,
   output logic [31:0] cfg_wdata_o,
   output logic [3:0]  cfg_strb_o,
   input  logic [31:0] cfg_rdata_i,
   input  logic        cfg_rdy_i,
   output logic        busy_o,
   output logic [15:0] timeout_cnt_o
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   state_e          state_q;
   logic [1:0]      byte_cnt_q;
   logic [31:0]     addr_q;
   logic [31:0]     wdata_q;
   logic            wr_q;
   logic            sel_q;
   logic            ena_q;
   logic [3:0]      strb_q;
   logic [TO_W-1:0] to_cnt_q;
   logic [15:0]     timeout_cnt_q;
   logic [39:0]     rsp_q;
   logic [2:0]      rsp_idx_q;
   logic [2:0]      rsp_last_q;
   logic            tx_vld_q;
   logic            rx_rdy_q;
   logic            busy_q;
   logic            byte_fire_s;

   assign byte_fire_s = rx_vld_i & rx_rdy_q;

   // Bridge FSM; every output is a register updated together with the state.
   always_ff @(posedge cfg_clk_i or negedge cfg_rstn_i) begin
      if (!cfg_rstn_i) begin
         state_q       <= IDLE;
         byte_cnt_q    <= 2'd0;
         addr_q        <= 32'd0;
         wdata_q       <= 32'd0;
         wr_q          <= 1'b0;
         sel_q         <= 1'b0;
         ena_q         <= 1'b0;
         strb_q        <= 4'h0;
         to_cnt_q      <= '0;
         timeout_cnt_q <= 16'd0;
         rsp_q         <= 40'd0;
         rsp_idx_q     <= 3'd0;
         rsp_last_q    <= 3'd0;
         tx_vld_q      <= 1'b0;
         rx_rdy_q      <= 1'b1;
         busy_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (byte_fire_s) begin
                  busy_q <= 1'b1;
                  if (rx_data_i == OP_WR || rx_data_i == OP_RD) begin
                     wr_q       <= (rx_data_i == OP_WR);
                     byte_cnt_q <= 2'd0;
                     state_q    <= ADDR;
                  end else begin
                     rsp_q      <= {RSP_BAD, 32'd0};
                     rsp_idx_q  <= 3'd0;
                     rsp_last_q <= 3'd0;
                     tx_vld_q   <= 1'b1;
                     rx_rdy_q   <= 1'b0;
                     state_q    <= RESP;
                  end
               end
            end
            ADDR: begin
               if (byte_fire_s) begin
                  addr_q     <= {addr_q[23:0], rx_data_i};
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd3) begin
                     if (wr_q) begin
                        state_q <= DATA;
                     end else begin
                        rx_rdy_q <= 1'b0;
                        sel_q    <= 1'b1;
                        strb_q   <= 4'hF;
                        state_q  <= SETUP;
                     end
                  end
               end
            end
            DATA: begin
               if (byte_fire_s) begin
                  wdata_q    <= {wdata_q[23:0], rx_data_i};
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd3) begin
                     rx_rdy_q <= 1'b0;
                     sel_q    <= 1'b1;
                     strb_q   <= 4'hF;
                     state_q  <= SETUP;
                  end
               end
            end
            SETUP: begin
               ena_q    <= 1'b1;
               to_cnt_q <= '0;
               state_q  <= ACCESS;
            end
            ACCESS: begin
               // rdata is only valid while ena&sel, so it is captured on the rdy cycle itself
               if (cfg_rdy_i || to_cnt_q == TO_LAST) begin
                  sel_q      <= 1'b0;
                  ena_q      <= 1'b0;
                  strb_q     <= 4'h0;
                  rsp_idx_q  <= 3'd0;
                  tx_vld_q   <= 1'b1;
                  state_q    <= RESP;
                  if (cfg_rdy_i) begin
                     rsp_q      <= wr_q ? {RSP_OK, 32'd0} : {RSP_OK, cfg_rdata_i};
                     rsp_last_q <= wr_q ? 3'd0 : 3'd4;
                  end else begin
                     rsp_q         <= {RSP_TO, 32'd0};
                     rsp_last_q    <= 3'd0;
                     timeout_cnt_q <= sat_inc16(timeout_cnt_q);
                  end
               end else begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
               end
            end
            RESP: begin
               if (tx_rdy_i) begin
                  if (rsp_idx_q == rsp_last_q) begin
                     tx_vld_q <= 1'b0;
                     rx_rdy_q <= 1'b1;
                     busy_q   <= 1'b0;
                     state_q  <= IDLE;
                  end else begin
                     rsp_q     <= {rsp_q[31:0], 8'd0};
                     rsp_idx_q <= rsp_idx_q + 3'd1;
                  end
               end
            end
            default: begin
               sel_q    <= 1'b0;
               ena_q    <= 1'b0;
               strb_q   <= 4'h0;
               tx_vld_q <= 1'b0;
               rx_rdy_q <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign rx_rdy_o      = rx_rdy_q;
   assign tx_data_o     = rsp_q[39:32];
   assign tx_vld_o      = tx_vld_q;
   assign cfg_addr_o    = addr_q;
   assign cfg_sel_o     = sel_q;
   assign cfg_ena_o     = ena_q;
   assign cfg_wr_o      = wr_q;
   assign cfg_wdata_o   = wdata_q;
   assign cfg_strb_o    = strb_q;
   assign busy_o        = busy_q;
   assign timeout_cnt_o = timeout_cnt_q;

endmodule

// File: tb/tb_cmd2apb_master.sv
// Self-checking bench for cmd2apb_master: directed scenarios plus randomized
// frames checked against a transaction-level model of the bridge.
module tb_cmd2apb_master;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data_i = 8'd0;
   logic        rx_vld_i = 1'b0;
   logic        rx_rdy_o;
   logic [7:0]  tx_data_o;
   logic        tx_vld_o;
   logic        tx_rdy_i = 1'b0;
   logic [31:0] cfg_addr_o;
   logic        cfg_sel_o;
   logic        cfg_ena_o;
   logic        cfg_wr_o;
   logic [31:0] cfg_wdata_o;
   logic [3:0]  cfg_strb_o;
   logic [31:0] cfg_rdata_i = 32'd0;
   logic        cfg_rdy_i = 1'b0;
   logic        busy_o;
   logic [15:0] timeout_cnt_o;

   int checks = 0;
   int failures = 0;
   int exp_to = 0;
   logic [31:0] mem [logic [31:0]];

   cmd2apb_master #(.TIMEOUT_CYC(TO)) dut (
      .cfg_clk_i    (clk),
      .cfg_rstn_i   (rst_n),
      .rx_data_i    (rx_data_i),
      .rx_vld_i     (rx_vld_i),
      .rx_rdy_o     (rx_rdy_o),
      .tx_data_o    (tx_data_o),
      .tx_vld_o     (tx_vld_o),
      .tx_rdy_i     (tx_rdy_i),
      .cfg_addr_o   (cfg_addr_o),
      .cfg_sel_o    (cfg_sel_o),
      .cfg_ena_o    (cfg_ena_o),
      .cfg_wr_o     (cfg_wr_o),
      .cfg_wdata_o  (cfg_wdata_o),
      .cfg_strb_o   (cfg_strb_o),
      .cfg_rdata_i  (cfg_rdata_i),
      .cfg_rdy_i    (cfg_rdy_i),
      .busy_o       (busy_o),
      .timeout_cnt_o(timeout_cnt_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=hang required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      for (int g = 0; g < gap; g++) @(negedge clk);
      @(negedge clk);
      rx_data_i = b;
      rx_vld_i  = 1'b1;
      while (!rx_rdy_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("rx_accept_wait", 32'(rx_rdy_o), 32'd1);
      @(posedge clk);
      #1;
      rx_vld_i  = 1'b0;
      rx_data_i = 8'($urandom);
   endtask

   // Plays the APB slave: w wait cycles then rdy (w >= TO means never ready).
   task automatic apb_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                           input int w, input logic [31:0] rd);
      int n = 0;
      @(negedge clk);
      while (!cfg_sel_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("setup_sel", 32'(cfg_sel_o), 32'd1);
      check("setup_ena", 32'(cfg_ena_o), 32'd0);
      check("setup_addr", cfg_addr_o, a);
      check("setup_wr", 32'(cfg_wr_o), 32'(wr));
      check("setup_strb", 32'(cfg_strb_o), 32'hF);
      check("setup_rx_rdy", 32'(rx_rdy_o), 32'd0);
      check("setup_busy", 32'(busy_o), 32'd1);
      if (wr) check("setup_wdata", cfg_wdata_o, wd);
      @(posedge clk);
      #1;
      for (int k = 1; k <= TO; k++) begin
         @(negedge clk);
         check("access_sel_ena", {30'd0, cfg_sel_o, cfg_ena_o}, 32'd3);
         check("access_addr", cfg_addr_o, a);
         check("access_wr", 32'(cfg_wr_o), 32'(wr));
         if (k == w + 1) begin
            cfg_rdy_i   = 1'b1;
            cfg_rdata_i = rd;
         end
         @(posedge clk);
         #1;
         cfg_rdy_i   = 1'b0;
         cfg_rdata_i = $urandom;
         if (k == w + 1) break;
      end
      @(negedge clk);
      check("after_access_sel_ena", {30'd0, cfg_sel_o, cfg_ena_o}, 32'd0);
      check("after_access_strb", 32'(cfg_strb_o), 32'd0);
   endtask

   task automatic get_rsp(input logic [7:0] q[$], input int hold0, input int hold_rest);
      for (int i = 0; i < q.size(); i++) begin
         int n = 0;
         int hold = (i == 0) ? hold0 : hold_rest;
         @(negedge clk);
         while (!tx_vld_o && n < 50) begin
            @(negedge clk);
            n++;
         end
         for (int h = 0; h < hold; h++) begin
            check("bp_tx_data", 32'(tx_data_o), 32'(q[i]));
            check("bp_rx_rdy", 32'(rx_rdy_o), 32'd0);
            @(negedge clk);
         end
         check("tx_vld", 32'(tx_vld_o), 32'd1);
         check("tx_data", 32'(tx_data_o), 32'(q[i]));
         check("resp_no_apb", 32'(cfg_sel_o), 32'd0);
         tx_rdy_i = 1'b1;
         @(posedge clk);
         #1;
         tx_rdy_i = 1'b0;
      end
      @(negedge clk);
      check("end_tx_vld", 32'(tx_vld_o), 32'd0);
      check("end_busy", 32'(busy_o), 32'd0);
      check("end_rx_rdy", 32'(rx_rdy_o), 32'd1);
   endtask

   // op: 0 write, 1 read, 2 bad opcode. Expected response comes from the model.
   task automatic run_frame(input int op, input logic [31:0] a, input logic [31:0] wd,
                            input int w, input int gap, input int hold0, input int hold_rest);
      logic [7:0]  q[$];
      logic [7:0]  b;
      logic [31:0] rd;
      if (op == 2) begin
         do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
         send_byte(b, gap);
         q = '{8'h3F};
      end else begin
         send_byte((op == 0) ? 8'h57 : 8'h52, gap);
         for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], gap);
         if (op == 0) for (int i = 3; i >= 0; i--) send_byte(wd[8*i +: 8], gap);
         rd = mem.exists(a) ? mem[a] : $urandom;
         apb_xfer(a, (op == 0), wd, w, rd);
         if (w >= TO) begin
            q = '{8'h45};
            if (exp_to < 65535) exp_to++;
         end else if (op == 0) begin
            mem[a] = wd;
            q = '{8'h4B};
         end else begin
            q = '{8'h4B, rd[31:24], rd[23:16], rd[15:8], rd[7:0]};
         end
      end
      get_rsp(q, hold0, hold_rest);
      check("timeout_cnt", 32'(timeout_cnt_o), 32'(exp_to));
   endtask

   initial begin
      int n;
      #12;
      check("rst_rx_rdy", 32'(rx_rdy_o), 32'd1);
      check("rst_tx_vld", 32'(tx_vld_o), 32'd0);
      check("rst_tx_data", 32'(tx_data_o), 32'd0);
      check("rst_sel_ena", {30'd0, cfg_sel_o, cfg_ena_o}, 32'd0);
      check("rst_wr", 32'(cfg_wr_o), 32'd0);
      check("rst_addr", cfg_addr_o, 32'd0);
      check("rst_wdata", cfg_wdata_o, 32'd0);
      check("rst_strb", 32'(cfg_strb_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_timeout_cnt", 32'(timeout_cnt_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_frame(0, 32'h0000_0004, 32'h1234_5678, 2, 0, 0, 0);
      run_frame(1, 32'h0000_0004, 32'd0, 3, 0, 0, 0);
      run_frame(1, 32'h0000_0008, 32'd0, 20, 0, 0, 0);
      run_frame(1, 32'h0000_0004, 32'd0, 0, 0, 0, 0);
      run_frame(1, 32'h0000_0004, 32'd0, TO - 1, 0, 0, 0);
      run_frame(0, 32'h0000_0010, 32'hCAFE_F00D, TO, 0, 0, 0);
      run_frame(2, 32'd0, 32'd0, 0, 0, 0, 0);
      run_frame(0, 32'h0000_0013, 32'hA5A5_5A5A, 1, 0, 0, 0);
      run_frame(1, 32'h0000_0013, 32'd0, 2, 0, 20, 0);

      for (int i = 0; i < 30; i++) begin
         int r = $urandom_range(0, 9);
         int op = (r == 0) ? 2 : (r < 5) ? 0 : 1;
         logic [31:0] a = 32'h1000_0000 | 32'($urandom_range(0, 7));
         if ($urandom_range(0, 4) == 0) a = $urandom;
         run_frame(op, a, $urandom, $urandom_range(0, 17), $urandom_range(0, 2),
                   $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // Async reset in the middle of an ACCESS phase.
      send_byte(8'h52, 0);
      for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
      n = 0;
      @(negedge clk);
      while (!cfg_ena_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("pre_reset_ena", 32'(cfg_ena_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_sel_ena", {30'd0, cfg_sel_o, cfg_ena_o}, 32'd0);
      check("arst_tx_vld", 32'(tx_vld_o), 32'd0);
      check("arst_busy", 32'(busy_o), 32'd0);
      check("arst_rx_rdy", 32'(rx_rdy_o), 32'd1);
      check("arst_timeout_cnt", 32'(timeout_cnt_o), 32'd0);
      exp_to = 0;
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(1, 32'h0000_0004, 32'd0, 1, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
